// File: rtl/count_arbiter.sv
// count_arbiter: time-shares one counter between NREQ one-shot delay requesters.
// Define COUNT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module count_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned COUNTER_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*COUNTER_SIZE-1:0] period,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic                         busy,
  output logic                         ctr_clr_n,
  output logic                         ctr_enable,
  output logic [7:0]                   ctr_mode,
  output logic [COUNTER_SIZE-1:0]      ctr_match,
  input  logic                         ctr_match_occured
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [COUNTER_SIZE-1:0] match_q, match_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic                    clr_rel_q;

  logic [IdxW-1:0]         win_idx;
  logic                    win_found;

  logic [COUNTER_SIZE-1:0] period_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_period
    assign period_arr[i] = period[i*COUNTER_SIZE +: COUNTER_SIZE];
  end

`ifdef COUNT_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the first hit after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    sum       = '0;
    cand      = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      sum  = {1'b0, ptr_q} + (IdxW+1)'(k);
      cand = (sum >= (IdxW+1)'(NREQ)) ? IdxW'(sum - (IdxW+1)'(NREQ)) : sum[IdxW-1:0];
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StDone) begin
      ptr_d = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      match_q   <= '0;
      gnt_q     <= '0;
      clr_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      match_q   <= match_d;
      gnt_q     <= gnt_d;
      clr_rel_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = match_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d   = win_idx;
          match_d = period_arr[win_idx];
          gnt_d   = NREQ'(1) << win_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (match_q == '0) begin
          gnt_d   = '0;
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Abandon wins over a match seen in the same cycle.
        if (!req[idx_q]) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else if (ctr_match_occured) begin
          gnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    gnt        = gnt_q;
    done       = '0;
    busy       = (state_q != StIdle);
    ctr_enable = 1'b0;
    ctr_clr_n  = clr_rel_q;
    ctr_mode   = 8'h03;
    ctr_match  = match_q;
    unique case (state_q)
      StLoad:  ctr_clr_n  = 1'b0;
      StRun:   ctr_enable = 1'b1;
      StDone:  done       = NREQ'(1) << idx_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed and random stimulus against a job-timeline reference model,
// with a behavioural stop-at-match counter attached to the counter port.
module tb_count_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CS   = 32;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req, gnt, done;
  logic [NREQ*CS-1:0]   period;
  logic                 busy, ctr_clr_n, ctr_enable, ctr_match_occured;
  logic [7:0]           ctr_mode;
  logic [CS-1:0]        ctr_match, cnt;

  always #5 clk = ~clk;

  count_arbiter #(.NREQ(NREQ), .COUNTER_SIZE(CS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .period            (period),
    .gnt               (gnt),
    .done              (done),
    .busy              (busy),
    .ctr_clr_n         (ctr_clr_n),
    .ctr_enable        (ctr_enable),
    .ctr_mode          (ctr_mode),
    .ctr_match         (ctr_match),
    .ctr_match_occured (ctr_match_occured)
  );

  // Shared counter: up-count, stop at match, async clear.
  always @(posedge clk or negedge ctr_clr_n) begin
    if (!ctr_clr_n) cnt <= '0;
    else if (ctr_enable && cnt != ctr_match) cnt <= cnt + 1;
  end
  assign ctr_match_occured = (cnt == ctr_match);

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one job at a time, described by its timeline.
  bit            m_job, m_ab, m_post_rst;
  int            m_owner, m_s, m_e, m_last, m_ptr;
  logic [CS-1:0] m_match;
  logic [NREQ-1:0] m_done_last;
  logic [NREQ-1:0] obs_done;
  int            obs_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
`ifdef COUNT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] e_gnt, e_done, oh;
    logic e_busy, e_en, e_clr;
    @(negedge clk);
    e_gnt  = '0;
    e_done = '0;
    e_busy = 1'b0;
    e_en   = 1'b0;
    e_clr  = !m_post_rst;
    if (m_job) begin
      oh     = NREQ'(1) << m_owner;
      e_busy = 1'b1;
      if (cyc < m_e) e_gnt = oh;
      if (!m_ab && cyc == m_e) e_done = oh;
      if (cyc == m_s + 1) e_clr = 1'b0;
      if (cyc >= m_s + 2 && cyc < m_e) e_en = 1'b1;
    end
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("done", 64'(done), 64'(e_done));
    check("busy", 64'(busy), 64'(e_busy));
    check("ctr_enable", 64'(ctr_enable), 64'(e_en));
    check("ctr_clr_n", 64'(ctr_clr_n), 64'(e_clr));
    check("ctr_match", 64'(ctr_match), 64'(m_match));
    check("ctr_mode", 64'(ctr_mode), 64'h03);
    if (done != '0) begin
      obs_done = done;
      obs_cyc  = cyc;
    end
    m_done_last = e_done;
    if (m_job) begin
      if (!m_ab && cyc >= m_s + 2 && cyc < m_e && !req[m_owner]) begin
        m_ab   = 1'b1;
        m_last = cyc;
      end
      if (cyc == m_last) begin
        if (!m_ab) m_ptr = (m_owner + 1) % NREQ;
        m_job = 1'b0;
      end
    end else if (req != '0) begin
      m_owner = pick(req);
      m_s     = cyc;
      m_match = period[m_owner*CS +: CS];
      m_e     = (m_match == '0) ? cyc + 2 : cyc + 3 + int'(m_match);
      m_last  = m_e;
      m_ab    = 1'b0;
      m_job   = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_post_rst = 1'b0;
    req = req & ~m_done_last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_period(input int i, input int p);
    period[i*CS +: CS] = CS'(p);
  endtask

  // Issue one request from an idle arbiter and measure its done latency.
  task automatic expect_done(input string tag, input int idx, input int p, input int lat);
    int t0;
    t0 = cyc;
    obs_cyc = -1;
    set_period(idx, p);
    req[idx] = 1'b1;
    for (int n = 0; n < lat + 6; n++) begin
      cycle();
      if (obs_cyc >= t0 && obs_done[idx]) break;
    end
    check(tag, 64'(obs_cyc >= t0 ? obs_cyc - t0 : -1), 64'(lat));
  endtask

  initial begin
    int t0;
    m_job = 0; m_ab = 0; m_ptr = 0; m_match = '0; m_done_last = '0; m_post_rst = 1;
    obs_done = '0; obs_cyc = -1;
    req = '0;
    period = '0;
    reset_n = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_clr_n", 64'(ctr_clr_n), 64'h0);
    check("rst_mode", 64'(ctr_mode), 64'h03);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);

    // Single request, period 5.
    expect_done("single_lat", 1, 5, 8);
    idle(3);

    // Zero period.
    expect_done("zero_lat", 3, 0, 2);
    idle(2);

    // All requesters held, period 2 each.
    for (int i = 0; i < NREQ; i++) set_period(i, 2);
    for (int n = 0; n < 32; n++) begin
      req = '1;
      cycle();
    end
    req = '0;
    idle(8);

    // Abandon mid-run, then a normal job.
    set_period(2, 100);
    req[2] = 1'b1;
    idle(20);
    req[2] = 1'b0;
    idle(4);
    expect_done("after_abandon_lat", 0, 3, 6);
    idle(2);

    // Period changed during RUN must not affect the running job.
    t0 = cyc;
    obs_cyc = -1;
    set_period(1, 10);
    req[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (n == 5) set_period(1, 3);
      cycle();
      if (obs_cyc >= t0 && obs_done[1]) break;
    end
    check("period_sample_lat", 64'(obs_cyc >= t0 ? obs_cyc - t0 : -1), 64'd13);
    idle(2);

    // Reset in the middle of a long job.
    expect_done("warm_lat", 2, 1, 4);
    idle(1);
    set_period(2, 50);
    req[2] = 1'b1;
    idle(10);
    req = '0;
    reset_n = 1'b0;
    #1;
    check("midrst_gnt", 64'(gnt), 64'h0);
    check("midrst_en", 64'(ctr_enable), 64'h0);
    check("midrst_clr_n", 64'(ctr_clr_n), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_match", 64'(ctr_match), 64'h0);
    m_job = 0; m_ab = 0; m_ptr = 0; m_match = '0; m_done_last = '0; m_post_rst = 1;
    #1;
    reset_n = 1'b1;
    idle(1);
    // Pointer back at 0: requester 0 wins among all.
    for (int i = 0; i < NREQ; i++) set_period(i, 1);
    t0 = cyc;
    obs_cyc = -1;
    req = '1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (obs_cyc >= t0 && obs_done[0]) break;
    end
    check("post_rst_lat", 64'(obs_cyc >= t0 ? obs_cyc - t0 : -1), 64'd4);
    idle(30);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req[i] = 1'b1;
            set_period(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9)));
          end
        end else if (m_job && m_owner == i && $urandom_range(0, 60) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 20) == 0) begin
          set_period(i, int'($urandom_range(0, 9)));
        end
      end
      cycle();
    end
    req = '0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
# count_arbiter

Time-shares one `count` counter instance between `NREQ` requesters that each need a one-shot delay of a requester-supplied length. The block arbitrates pending requests and programs the counter for the winner: it sets match value and mode, clears the counter and enables it. It then waits for the match and returns a one-cycle completion pulse to the winner. It sits between the requesting control blocks and the single shared counter.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `COUNTER_SIZE`, 32: counter and period width in bits; must equal the attached counter's width.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request per requester; held high until `done` or abandon.
- `period` in NREQ*COUNTER_SIZE: delay per requester; slice i is bits [i*COUNTER_SIZE +: COUNTER_SIZE].
- `gnt` out NREQ: one-hot grant, high for the whole job.
- `done` out NREQ: one-cycle completion pulse to the served requester.
- `busy` out 1: high in any state other than IDLE.
- `ctr_clr_n` out 1: drives the counter's `reset_n`; low exactly one cycle per job.
- `ctr_enable` out 1: counter enable.
- `ctr_mode` out 8: counter mode; constant 8'h03 (bit0=1 up, bit1=1 stop at match).
- `ctr_match` out COUNTER_SIZE: counter match value.
- `ctr_match_occured` in 1: counter's match flag.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state/registers only.
- IDLE
  - If `req` != 0: select winner `idx` per arbitration policy, latch `idx` and `period[idx]` into `ctr_match`, set `gnt[idx]`, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD
  - `ctr_clr_n` = 0, `ctr_enable` = 0.
  - If latched period == 0, go directly to DONE (no counting).
  - Otherwise go to RUN.
- RUN
  - `ctr_enable` = 1.
  - On `ctr_match_occured` = 1, go to DONE.
  - Abandon: if `req[idx]` drops, go to IDLE, clear `gnt`, no `done` pulse. Abandon takes precedence over a same-cycle match.
- DONE
  - `done[idx]` = 1 for this single cycle; `gnt` = 0; `ctr_enable` = 0.
  - Round-robin pointer becomes (idx+1) mod NREQ.
  - Go to IDLE.
- Round-robin policy: search starts at the pointer, wraps at NREQ-1 -> 0. Pointer resets to 0 and changes only in DONE.
- Req changes on non-granted lines are ignored until the next IDLE.
- `period` is sampled only in IDLE; later changes do not affect the running job.
- Reset mid-job: all state clears immediately. The counter is cleared through `ctr_clr_n`, which resets to 0 and releases to 1 on the first clock edge.
- Reset values:
  - state = IDLE; `gnt`, `done`, `busy`, `ctr_enable`, `ctr_match` = 0.
  - `ctr_clr_n` = 0, released to 1 on the first clock edge.
  - `ctr_mode` = 8'h03.

## Timing
- Request sampled at edge 0 (state IDLE) -> `gnt` high from cycle 1 (LOAD, `ctr_clr_n` low).
- Cycle 2 onward is RUN; the counter increments once per cycle from 0.
- The counter equals `period` in cycle 2+period -> `done` high in cycle 3+period.
- Period 0 -> `done` in cycle 2.
- Back-to-back: the next grant appears at the earliest one cycle after `done` (IDLE cycle). Per-job overhead is 3 cycles plus the period.
- Max period 2^COUNTER_SIZE-1; no wrap is possible because the match stops RUN first.

## Configuration
- `COUNT_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; pointer logic is compiled out.
- Not defined: round-robin as described above.

## Test plan
- Single request: req=4'b0010, period[1]=5 -> `gnt`=4'b0010 at cycle 1, `ctr_clr_n` low at cycle 1 only, `done`=4'b0010 at cycle 8, `busy` low at cycle 9.
- All requesting, period 2 each, round-robin: grants in order 0,1,2,3,0; each `done` 6 cycles apart. With `COUNT_ARB_FIXED_PRIO_EN` defined, grant stays at 0 while req[0] is held.
- Zero period: req[3] with period 0 -> `done[3]` at cycle 2; `ctr_enable` never high.
- Abandon: req[2], period 100, req[2] dropped at cycle 20 -> state returns to IDLE, no `done`, `ctr_enable` low, next request served normally.
- Reset mid-RUN: assert reset_n low at cycle 10 of a period-50 job -> `gnt`/`ctr_enable` 0 immediately, `ctr_clr_n` 0, pointer 0; after release, a new req[0] completes with nominal latency.
- Period sampling: change period[1] from 10 to 3 during RUN -> `done` still at cycle 13.
